// File: rtl/serial_adder_fsm_if.sv
// Handshake bundle for serial_adder_fsm.
//   Upstream:   start (valid), ready, a, b, cin [, sub]
//   Downstream: valid, ack, sum, cout
//   Status:     busy
// Optional macro SERIAL_ADDER_SUB_EN adds the sub signal.
// Modport slave is the adder side; master is the driving/consuming side.
interface serial_adder_fsm_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic         ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout;
  logic         valid;
  logic         ack;
  logic         busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  modport slave (
    input  start, a, b, cin, ack,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output ready, sum, cout, valid, busy
  );

  modport master (
    output start, a, b, cin, ack,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  ready, sum, cout, valid, busy
  );
endinterface

// File: rtl/full_adder_join.sv
// Single-bit full adder cell.
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   cout    : carry-out
module full_adder_join (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial N-bit adder: operands are accepted on a start/ready handshake, added
// LSB-first through one full_adder_join cell (one bit per clock) and the result is
// offered on a valid/ack handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_fsm_if.slave (start, ready, a, b, cin, sum, cout, valid, ack, busy)
// Optional macro SERIAL_ADDER_SUB_EN adds bus.sub: when set on accept, B is inverted and
// the carry seeds to 1, giving A - B with cout=1 meaning no borrow.
module serial_adder_fsm #(
  parameter int unsigned N = 4
) (
  input logic              clk,
  input logic              rst,
  serial_adder_fsm_if.slave bus
);
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;

  logic          fa_sum, fa_cout;
  logic [N-1:0]  b_load;
  logic          carry_load;

  full_adder_join u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: A + ~B + 1.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          res_d   = '0;
          cnt_d   = '0;
          cout_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Sum bits enter at the MSB so that after N shifts bit 0 holds the LSB.
        res_d   = {fa_sum, res_q[N-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = fa_cout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        if (bus.ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.busy  = (state_q == StRun);
  assign bus.valid = (state_q == StDone);
  assign bus.sum   = res_q;
  assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm with N=4.
module tb_serial_adder_fsm;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_adder_fsm_if #(.N(N)) bus ();

  serial_adder_fsm #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.ack   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    #3;
    total++;
    if ({bus.ready, bus.valid, bus.busy, bus.sum, bus.cout} !== {3'b100, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_in: rdy/val/busy/sum/cout got %b %b %b %0d %b want 1 0 0 0 0",
               bus.ready, bus.valid, bus.busy, bus.sum, bus.cout);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    total++;
    if ({bus.ready, bus.valid, bus.busy, bus.sum, bus.cout} !== {3'b100, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_idle: rdy/val/busy/sum/cout got %b %b %b %0d %b want 1 0 0 0 0",
               bus.ready, bus.valid, bus.busy, bus.sum, bus.cout);
    end
  endtask

  // One full operation with ack held high; checks latency, result and return to idle.
  task automatic test_add(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic [3:0] exp_sum, input logic exp_cout);
    bus.ack   = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = 4'hx;
    bus.b     = 4'hx;
    bus.cin   = 1'bx;
    total++;
    if ({bus.ready, bus.busy, bus.valid} !== 3'b010) begin
      bad++;
      $display("FAIL %s_run: rdy/busy/val got %b%b%b want 010", name, bus.ready, bus.busy,
               bus.valid);
    end
    for (int i = 0; i < N - 1; i++) begin
      tick();
      total++;
      if (bus.valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_early_valid: cycle %0d got %b want 0", name, i + 1, bus.valid);
      end
    end
    tick();
    total++;
    if ({bus.valid, bus.busy, bus.ready, bus.sum, bus.cout} !== {3'b100, exp_sum, exp_cout})
    begin
      bad++;
      $display("FAIL %s_result: val/busy/rdy/sum/cout got %b %b %b %0d %b want 1 0 0 %0d %b",
               name, bus.valid, bus.busy, bus.ready, bus.sum, bus.cout, exp_sum, exp_cout);
    end
    tick();
    total++;
    if ({bus.ready, bus.valid, bus.busy} !== 3'b100) begin
      bad++;
      $display("FAIL %s_ack: rdy/val/busy got %b%b%b want 100", name, bus.ready, bus.valid,
               bus.busy);
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_sweep();
    test_add("zero", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    test_add("wrap", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    test_add("max", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);
    test_add("cin_only", 4'd6, 4'd9, 1'b1, 4'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    bus.ack   = 1'b0;
    bus.a     = 4'd9;
    bus.b     = 4'd4;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    // Start pulse with new operands during RUN must not be captured.
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (N - 1) tick();
    total++;
    if ({bus.valid, bus.sum, bus.cout} !== {1'b1, 4'd13, 1'b0}) begin
      bad++;
      $display("FAIL bp_result: val/sum/cout got %b %0d %b want 1 13 0", bus.valid, bus.sum,
               bus.cout);
    end
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3);
      tick();
      total++;
      if ({bus.valid, bus.ready, bus.busy, bus.sum, bus.cout} !== {3'b100, 4'd13, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d val/rdy/busy/sum/cout got %b %b %b %0d %b want 1 0 0 13 0",
                 i, bus.valid, bus.ready, bus.busy, bus.sum, bus.cout);
      end
    end
    bus.start = 1'b0;
    bus.ack   = 1'b1;
    tick();
    bus.ack = 1'b0;
    total++;
    if ({bus.ready, bus.valid, bus.busy} !== 3'b100) begin
      bad++;
      $display("FAIL bp_ack: rdy/val/busy got %b%b%b want 100", bus.ready, bus.valid, bus.busy);
    end
    tick();
    total++;
    if ({bus.ready, bus.busy} !== 2'b10) begin
      bad++;
      $display("FAIL bp_no_restart: rdy/busy got %b%b want 10", bus.ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    bus.ack   = 1'b1;
    bus.a     = 4'd7;
    bus.b     = 4'd7;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({bus.ready, bus.valid, bus.busy, bus.sum, bus.cout} !== {3'b100, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_async: rdy/val/busy/sum/cout got %b %b %b %0d %b want 1 0 0 0 0",
               bus.ready, bus.valid, bus.busy, bus.sum, bus.cout);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      if (bus.valid !== 1'b0) seen_valid = 1'b1;
    end
    total++;
    if (seen_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_valid: got valid=1 after abort want 0");
    end
    test_add("post_rst", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    bus.sub = 1'b1;
    test_add("sub_borrow", 4'd3, 4'd5, 1'b0, 4'd14, 1'b0);
    test_add("sub_ok", 4'd5, 4'd3, 1'b0, 4'd2, 1'b1);
    test_add("sub_cin_ign", 4'd5, 4'd3, 1'b1, 4'd2, 1'b1);
    bus.sub = 1'b0;
    test_add("sub_off", 4'd5, 4'd3, 1'b1, 4'd9, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_add("basic", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0);
    test_sweep();
    test_backpressure();
    test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
